// File: rtl/kyber_pkg.sv
// ============================================================================
// Module   : kyber_pkg
// Purpose  : Shared Kyber constants and the butterfly mode type.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package kyber_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int KYBER_LOGQ    = 12;
  localparam int BARRETT_M     = 5039;
  localparam int BARRETT_SHIFT = 24;
  localparam int BFU_LATENCY   = 4;

  typedef enum logic {
    BFU_CT = 1'b0,
    BFU_GS = 1'b1
  } bfu_mode_e;

endpackage

`default_nettype wire

// File: rtl/ntt_butterfly_if.sv
// ============================================================================
// Module   : ntt_butterfly_if
// Purpose  : Operand/result handshake bundle of the NTT butterfly.
//            in_mode exists only when NTT_BFU_INTT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ntt_butterfly_if #(
  parameter int LOGQ = 12
) ();

  logic            in_valid;
  logic            in_ready;
  logic [LOGQ-1:0] in_a;
  logic [LOGQ-1:0] in_b;
  logic [LOGQ-1:0] in_w;
`ifdef NTT_BFU_INTT_EN
  logic            in_mode;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] out_a;
  logic [LOGQ-1:0] out_b;

`ifdef NTT_BFU_INTT_EN
  modport master (output in_valid, in_a, in_b, in_w, in_mode, out_ready,
                  input  in_ready, out_valid, out_a, out_b);
  modport slave  (input  in_valid, in_a, in_b, in_w, in_mode, out_ready,
                  output in_ready, out_valid, out_a, out_b);
`else
  modport master (output in_valid, in_a, in_b, in_w, out_ready,
                  input  in_ready, out_valid, out_a, out_b);
  modport slave  (input  in_valid, in_a, in_b, in_w, out_ready,
                  output in_ready, out_valid, out_a, out_b);
`endif

endinterface

`default_nettype wire

// File: rtl/barrett_reduce.sv
// ============================================================================
// Module   : barrett_reduce
// Purpose  : Barrett reduction of a 2*LOGQ-bit product: registers the quotient
//            estimate and product, then applies the single final correction.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module barrett_reduce
  import kyber_pkg::*;
#(
  parameter int            LOGQ    = 12,
  parameter logic [LOGQ:0] Q_VALUE = 13'd3329
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*LOGQ-1:0] p,
  output logic [LOGQ-1:0]   r
);

  localparam logic [LOGQ:0] c_m = (LOGQ+1)'(BARRETT_M);

  logic [LOGQ-1:0]   w_qe;
  logic [LOGQ-1:0]   r_qe;
  logic [2*LOGQ-1:0] r_p;
  logic [LOGQ:0]     w_t;

  assign w_qe = LOGQ'(((3*LOGQ)'(p) * (3*LOGQ)'(c_m)) >> BARRETT_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qe <= '0;
      r_p  <= '0;
    end else if (en) begin
      r_qe <= w_qe;
      r_p  <= p;
    end
  end

  // The estimate undershoots by at most one q, so t fits in LOGQ+1 bits.
  assign w_t = (LOGQ+1)'(r_p - (2*LOGQ)'(r_qe) * (2*LOGQ)'(Q_VALUE));
  assign r   = (w_t >= Q_VALUE) ? LOGQ'(w_t - Q_VALUE) : LOGQ'(w_t);

endmodule

`default_nettype wire

// File: rtl/modsub.sv
// ============================================================================
// Module   : modsub
// Purpose  : Combinational modular subtraction d = (a - b) mod q, a,b < q.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module modsub #(
  parameter int            LOGQ    = 12,
  parameter logic [LOGQ:0] Q_VALUE = 13'd3329
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  output logic [LOGQ-1:0] d
);

  assign d = (a >= b) ? LOGQ'({1'b0, a} - {1'b0, b})
                      : LOGQ'({1'b0, a} + Q_VALUE - {1'b0, b});

endmodule

`default_nettype wire

// File: rtl/ntt_butterfly.sv
// ============================================================================
// Module   : ntt_butterfly
// Purpose  : 4-stage radix-2 NTT butterfly (CT; GS when NTT_BFU_INTT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_butterfly
  import kyber_pkg::*;
#(
  parameter int            LOGQ    = KYBER_LOGQ,
  parameter logic [LOGQ:0] Q_VALUE = 13'd3329
) (
  input  logic           clk,
  input  logic           rst,
  ntt_butterfly_if.slave bus
);

  function automatic logic [LOGQ-1:0] f_modadd(input logic [LOGQ-1:0] x,
                                               input logic [LOGQ-1:0] y);
    logic [LOGQ:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= Q_VALUE) ? LOGQ'(s - Q_VALUE) : LOGQ'(s);
  endfunction

  logic              w_advance;
  logic [LOGQ-1:0]   w_a1_d, w_b1_d;
  logic [LOGQ-1:0]   w_r, w_ct_b, w_oa_d, w_ob_d;
  logic              r_v1, r_v2, r_v3, r_v4;
  logic [LOGQ-1:0]   r_a1, r_b1, r_w1, r_a2, r_a3, r_oa, r_ob;
  logic [2*LOGQ-1:0] r_p2;

  // A held output freezes every stage at once; no bubble collapsing.
  assign w_advance     = !(r_v4 && !bus.out_ready);
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_v4;
  assign bus.out_a     = r_oa;
  assign bus.out_b     = r_ob;

`ifdef NTT_BFU_INTT_EN
  bfu_mode_e       r_m1, r_m2, r_m3;
  logic [LOGQ-1:0] w_pre_d;

  modsub #(.LOGQ(LOGQ), .Q_VALUE(Q_VALUE)) u_presub (
    .a (bus.in_a),
    .b (bus.in_b),
    .d (w_pre_d)
  );

  assign w_a1_d = bus.in_mode ? f_modadd(bus.in_a, bus.in_b) : bus.in_a;
  assign w_b1_d = bus.in_mode ? w_pre_d : bus.in_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m1 <= BFU_CT;
      r_m2 <= BFU_CT;
      r_m3 <= BFU_CT;
    end else if (w_advance) begin
      r_m1 <= bfu_mode_e'(bus.in_mode);
      r_m2 <= r_m1;
      r_m3 <= r_m2;
    end
  end

  assign w_oa_d = (r_m3 == BFU_GS) ? r_a3 : f_modadd(r_a3, w_r);
  assign w_ob_d = (r_m3 == BFU_GS) ? w_r  : w_ct_b;
`else
  assign w_a1_d = bus.in_a;
  assign w_b1_d = bus.in_b;
  assign w_oa_d = f_modadd(r_a3, w_r);
  assign w_ob_d = w_ct_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
      r_w1 <= '0;
      r_a2 <= '0;
      r_p2 <= '0;
      r_a3 <= '0;
      r_oa <= '0;
      r_ob <= '0;
    end else if (w_advance) begin
      r_v1 <= bus.in_valid;
      r_a1 <= w_a1_d;
      r_b1 <= w_b1_d;
      r_w1 <= bus.in_w;
      r_v2 <= r_v1;
      r_a2 <= r_a1;
      r_p2 <= (2*LOGQ)'(r_b1) * (2*LOGQ)'(r_w1);
      r_v3 <= r_v2;
      r_a3 <= r_a2;
      r_v4 <= r_v3;
      r_oa <= w_oa_d;
      r_ob <= w_ob_d;
    end
  end

  barrett_reduce #(.LOGQ(LOGQ), .Q_VALUE(Q_VALUE)) u_barrett (
    .clk (clk),
    .rst (rst),
    .en  (w_advance),
    .p   (r_p2),
    .r   (w_r)
  );

  modsub #(.LOGQ(LOGQ), .Q_VALUE(Q_VALUE)) u_ctsub (
    .a (r_a3),
    .b (w_r),
    .d (w_ct_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_ntt_butterfly.sv
// ============================================================================
// Module   : tb_ntt_butterfly
// Purpose  : Directed self-checking bench for ntt_butterfly.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ntt_butterfly;

  localparam int c_q = 3329;

  typedef struct {
    int ea;
    int eb;
    int acc;
    bit lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out = 0;
  int   n_stall = 0;
  int   cur_ea = 0;
  int   cur_eb = 0;
  bit   cur_lat = 1'b0;
  exp_t exp_q[$];
  bit   prev_stall = 1'b0;
  int   prev_a = 0;
  int   prev_b = 0;

  ntt_butterfly_if #(.LOGQ(12)) bus ();

  ntt_butterfly #(.LOGQ(12), .Q_VALUE(13'd3329)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output scoreboard plus accept logging; all inputs are stable at negedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_a", int'(bus.out_a), prev_a);
        chk("hold_b", int'(bus.out_b), prev_b);
      end
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        chk("stall_in_ready", int'(bus.in_ready), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_a", int'(bus.out_a), e.ea);
          chk("out_b", int'(bus.out_b), e.eb);
          if (e.lat) chk("latency", cyc - e.acc, 4);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_a     = int'(bus.out_a);
      prev_b     = int'(bus.out_b);
      if (bus.in_valid && bus.in_ready) begin
        e.ea  = cur_ea;
        e.eb  = cur_eb;
        e.acc = cyc;
        e.lat = cur_lat;
        exp_q.push_back(e);
      end
    end
  end

  // Present one operand set and wait (bounded) until it is accepted.
  task automatic send(input int a, input int b, input int w, input bit m,
                      input int ea, input int eb, input bit lat);
    int guard;
    bit took;
    guard = 0;
    took  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 12'(a);
    bus.in_b = 12'(b);
    bus.in_w = 12'(w);
`ifdef NTT_BFU_INTT_EN
    bus.in_mode = m;
`endif
    cur_ea  = ea;
    cur_eb  = eb;
    cur_lat = lat;
    while (!took && guard < 100) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic int ref_r(input int b, input int w);
    return (b * w) % c_q;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a, b, w, r;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_w      = '0;
`ifdef NTT_BFU_INTT_EN
    bus.in_mode   = 1'b0;
`endif
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_a", int'(bus.out_a), 0);
    chk("rst_out_b", int'(bus.out_b), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // CT directed vectors
    send(100, 2, 17, 1'b0, 134, 66, 1'b1);
    idle();
    drain();
    send(3328, 3328, 3328, 1'b0, 0, 3327, 1'b1);
    send(0, 1, 1, 1'b0, 1, 3328, 1'b1);
    idle();
    drain();

    // Back-to-back stream with a 3-cycle output stall
    base    = n_out;
    n_stall = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a = $urandom_range(0, 3328);
          b = $urandom_range(0, 3328);
          w = $urandom_range(0, 3328);
          r = ref_r(b, w);
          send(a, b, w, 1'b0, (a + r) % c_q, (a - r + c_q) % c_q, 1'b0);
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", n_out - base, 8);
    chk("stall_cycles", n_stall, 3);

    // Reset with three items in flight
    send(100, 2, 17, 1'b0, 134, 66, 1'b0);
    send(7, 8, 9, 1'b0, 79, 3264, 1'b0);
    send(1, 2, 3, 1'b0, 7, 3324, 1'b0);
    idle();
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_a", int'(bus.out_a), 0);
    chk("midrst_out_b", int'(bus.out_b), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    base = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_output", n_out - base, 0);

`ifdef NTT_BFU_INTT_EN
    send(5, 10, 17, 1'b1, 15, 3244, 1'b1);
    idle();
    drain();
    send(100, 2, 17, 1'b0, 134, 66, 1'b1);
    send(5, 10, 17, 1'b1, 15, 3244, 1'b1);
    send(0, 1, 1, 1'b0, 1, 3328, 1'b1);
    send(3328, 3328, 3328, 1'b1, 3327, 0, 1'b1);
    idle();
    drain();
`endif

    // Reduction sweep: a=0, w=q-1 gives out_a = -b, out_b = b
    for (int bb = 0; bb < c_q; bb++) begin
      send(0, bb, 3328, 1'b0, (c_q - bb) % c_q, bb, 1'b1);
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ntt_butterfly.md
# ntt_butterfly

Pipelined radix-2 butterfly for the Kyber NTT datapath (q = 3329).
- Takes two reduced coefficients and a twiddle factor.
- Produces the Cooley-Tukey pair (a + w·b mod q, a − w·b mod q) behind a valid/ready handshake.
- Sits between the coefficient-memory read port and the write-back path, and reuses the existing modsub stage for its final subtraction.
- Optional Gentleman-Sande mode supports the inverse NTT.

## Interface
Parameters:
- LOGQ, 12, coefficient width
- Q_VALUE, 13'd3329, modulus (LOGQ+1 bits)

Ports:
- Clocking and reset (already decided): one clock, clk; reset rst, asynchronous, active-high.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  LOGQ  coefficient a, must be < Q
- in_b  in  LOGQ  coefficient b, must be < Q
- in_w  in  LOGQ  twiddle w, must be < Q
- in_mode  in  1  0 = CT, 1 = GS (present only with NTT_BFU_INTT_EN)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_a  out  LOGQ  first result, < Q
- out_b  out  LOGQ  second result, < Q

## Operation
- Transfer rules:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
- Four-stage pipeline. Each stage carries a valid bit, plus a mode bit when the GS feature is compiled.
- S1 (pre-op):
  - CT: register a, b, w unchanged.
  - GS: register s = a + b mod q (in the a slot), d = a − b mod q (in the b slot), and w.
- S2: register the 24-bit product p = b_slot · w, plus a_slot.
- S3: register qe = (p · 5039) >> 24 (36-bit intermediate), p, and a_slot.
- S4:
  - t = p − qe·q, with one conditional subtract if t ≥ q, giving r = w·b mod q.
  - CT: out_a = a + r mod q; out_b = modsub(a, r).
  - GS: out_a = a_slot (the sum); out_b = r.
  - Results are registered.
- Arithmetic rules:
  - Barrett error is bounded: t is in [0, 2q), so a single subtract suffices.
  - The modular add uses a 13-bit sum with a subtract-q-if-≥q correction.
- Stall rule: advance = !(out_valid && !out_ready). Every stage register updates only when advance = 1.
- in_ready = advance, which is combinational from out_valid and out_ready.
- Bubbles (invalid stages) propagate normally; there is no bubble collapsing.
- Operands ≥ Q are outside the contract; no output value is required for them.
- On reset:
  - All stage valids are 0; out_valid = 0.
  - out_a = 0, out_b = 0. Data registers reset to 0.
  - in_ready = 1.
- Reset mid-operation: all in-flight items are discarded; none are emitted after rst deasserts.

## Timing
- Latency: 4 cycles from an accepted input to out_valid, with no stalls and in either mode.
- Throughput: one butterfly per cycle while out_ready = 1.
- Stall:
  - out_valid && !out_ready freezes the whole pipeline.
  - out_a and out_b hold stable until the transfer.
  - in_ready = 0 in the same cycle.
- Simultaneous output transfer and input acceptance is permitted: a full pipeline keeps streaming.
- No combinational path from in_* to out_*. The only combinational path is out_ready/out_valid → in_ready.

## Configuration
- NTT_BFU_INTT_EN defined:
  - The in_mode port exists.
  - The per-stage mode bit and the S1 GS pre-add/pre-sub logic are compiled in.
- NTT_BFU_INTT_EN undefined:
  - No in_mode port; CT only.
  - S1 is a plain register stage, so latency stays 4.

## Structure
- kyber_pkg holds:
  - KYBER_Q = 3329, KYBER_LOGQ = 12
  - BARRETT_M = 5039, BARRETT_SHIFT = 24
  - BFU_LATENCY = 4
- One natural sub-module: barrett_reduce, which implements S3 and the S4 correction as a two-register slice with an enable.
- The existing modsub is instantiated for the CT b-output and for the GS pre-subtraction.

## Test plan
- CT basic: a=100, b=2, w=17 → out_a=134, out_b=66, out_valid exactly 4 cycles after the accept.
- CT wrap-around: a=3328, b=3328, w=3328 → product reduces to 1, out_a=0, out_b=3327. Also a=0, b=1, w=1 → out_a=1, out_b=3328.
- Back-to-back with stall:
  - Drive 8 random operand sets on consecutive cycles.
  - Hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready low during the stall, outputs held stable, all 8 results in order and matching the reference model.
- Reset mid-operation: assert rst with 3 items in flight → out_valid=0, outputs 0 immediately; no results appear after release.
- GS mode (macro defined): in_mode=1, a=5, b=10, w=17 → out_a=15, out_b=3244, latency 4. Interleave CT and GS items and check that each result follows its own mode.
- Exhaustive reduction check: sweep b over 0..3328 with w=3328 and a=0 → out_a = 3329−b (mod q), out_b = b.
